// File: rtl/psram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port PSRAM command arbiter.
package psram_port_arbiter_pkg;

  localparam int DEF_ADDR_W  = 22;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 32;

  // Sequencer states; INIT waits for the controller to finish its own init.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Identity of a requester port.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  // Width of a counter that must be able to hold the value t.
  function automatic int cnt_width(input int t);
    return $clog2(t + 1) + 1;
  endfunction

endpackage

// File: rtl/psram_port_arbiter.sv
// Two-port arbiter in front of a single PsramController command port.
// Each granted access is sequenced as: issue pulse, one guard cycle,
// wait for busy to fall (or time out), one-cycle ack to the owner.
module psram_port_arbiter
  import psram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int FIXED_PRIO     = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              bw0,
  input  logic              bw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_busy
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state, state_next;
  port_t             grant, grant_next;
  port_t             last_grant, last_grant_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              ack0_next, ack1_next;
  logic [DATA_W-1:0] rdata_next;
  logic              err_next, ready_next;
  logic              mem_read_next, mem_write_next, mem_byte_write_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_din_next;

  // Winner of an arbitration round. A lone requester always wins; on a tie
  // round-robin hands the grant to the port that was not served last, while
  // fixed priority always favours port 0.
  function automatic port_t pick_port(input logic r0, input logic r1,
                                      input port_t lg);
    port_t p;
    if (r0 && r1) begin
      if (FIXED_PRIO != 0) p = PORT0;
      else                 p = (lg == PORT0) ? PORT1 : PORT0;
    end else if (r1) begin
      p = PORT1;
    end else begin
      p = PORT0;
    end
    return p;
  endfunction

  // Next-state and next-output computation; every output is a register.
  always_comb begin
    state_next          = state;
    grant_next          = grant;
    last_grant_next     = last_grant;
    cnt_next            = cnt;
    ack0_next           = 1'b0;
    ack1_next           = 1'b0;
    rdata_next          = rdata;
    err_next            = err;
    ready_next          = ready;
    mem_read_next       = 1'b0;
    mem_write_next      = 1'b0;
    mem_byte_write_next = mem_byte_write;
    mem_addr_next       = mem_addr;
    mem_din_next        = mem_din;

    case (state)
      ST_INIT: begin
        if (!mem_busy) begin
          state_next = ST_IDLE;
          ready_next = 1'b1;
        end
      end

      ST_IDLE: begin
        if (req0 || req1) begin
          grant_next = pick_port(req0, req1, last_grant);
          if (grant_next == PORT1) begin
            mem_addr_next       = addr1;
            mem_din_next        = wdata1;
            mem_byte_write_next = bw1 & we1;
            mem_write_next      = we1;
            mem_read_next       = ~we1;
          end else begin
            mem_addr_next       = addr0;
            mem_din_next        = wdata0;
            mem_byte_write_next = bw0 & we0;
            mem_write_next      = we0;
            mem_read_next       = ~we0;
          end
          cnt_next   = '0;
          state_next = ST_GUARD;
        end
      end

      // The controller raises busy only one cycle after the command, so
      // busy is not trusted on this edge.
      ST_GUARD: begin
        cnt_next   = cnt + CNT_ONE;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_next = cnt + CNT_ONE;
        if (!mem_busy) begin
          rdata_next = mem_dout;
          ack0_next  = (grant == PORT0);
          ack1_next  = (grant == PORT1);
          state_next = ST_DONE;
        end else if (cnt >= CNT_LIMIT) begin
          // Give up on the controller: still release the requester so it
          // cannot hang, but flag the failure permanently.
          err_next   = 1'b1;
          ack0_next  = (grant == PORT0);
          ack1_next  = (grant == PORT1);
          state_next = ST_DONE;
        end
      end

      // Ack is visible this cycle; requests are not looked at here so the
      // requester has one edge to drop req before the next arbitration.
      ST_DONE: begin
        last_grant_next = grant;
        state_next      = ST_IDLE;
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Register bank for state, bookkeeping and all outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ST_INIT;
      grant          <= PORT0;
      last_grant     <= PORT1;
      cnt            <= '0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata          <= '0;
      err            <= 1'b0;
      ready          <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
    end else begin
      state          <= state_next;
      grant          <= grant_next;
      last_grant     <= last_grant_next;
      cnt            <= cnt_next;
      ack0           <= ack0_next;
      ack1           <= ack1_next;
      rdata          <= rdata_next;
      err            <= err_next;
      ready          <= ready_next;
      mem_read       <= mem_read_next;
      mem_write      <= mem_write_next;
      mem_byte_write <= mem_byte_write_next;
      mem_addr       <= mem_addr_next;
      mem_din        <= mem_din_next;
    end
  end

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Bench for psram_port_arbiter: one round-robin instance and one
// fixed-priority instance, each in front of a small controller model that
// raises busy for a programmable number of cycles after a command and
// returns data derived from the command address.
module tb_psram_port_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;

  typedef struct {
    logic        port;
    logic [15:0] data;
  } exp_t;

  logic          clk;
  logic          resetn;

  // Round-robin instance signals
  logic          req0, req1, we0, we1, bw0, bw1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err, ready;
  logic [DW-1:0] rdata;
  logic          mem_read, mem_write, mem_byte_write, mem_busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  // Fixed-priority instance signals
  logic          f_req0, f_req1;
  logic [AW-1:0] f_addr0, f_addr1;
  logic          f_ack0, f_ack1, f_err, f_ready;
  logic [DW-1:0] f_rdata;
  logic          f_mem_read, f_mem_write, f_mem_byte_write, f_mem_busy;
  logic [AW-1:0] f_mem_addr;
  logic [DW-1:0] f_mem_din, f_mem_dout;

  // Controller model knobs
  int            busy_len;
  logic          hold_busy;
  logic          stuck;
  logic          m_busy_q;
  int            m_cnt;
  logic          f_busy_q;
  int            f_cnt;

  // Activity counters (only ever incremented here)
  int            n_wr, n_rd, n_ack0, n_ack1, n_rd_bw;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_din;
  logic          last_wr_bw;

  int            n_checks;
  int            n_errors;
  exp_t          sb[$];

  function automatic logic [15:0] hash(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A ^ {10'b0, a[21:16]};
  endfunction

  psram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(32), .FIXED_PRIO(0)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .bw0(bw0), .bw1(bw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .ready(ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_write(mem_byte_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  psram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(32), .FIXED_PRIO(1)
  ) dut_fp (
    .clk(clk), .resetn(resetn),
    .req0(f_req0), .req1(f_req1), .we0(1'b0), .we1(1'b0),
    .bw0(1'b0), .bw1(1'b0),
    .addr0(f_addr0), .addr1(f_addr1), .wdata0(16'h0), .wdata1(16'h0),
    .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata), .err(f_err),
    .ready(f_ready),
    .mem_read(f_mem_read), .mem_write(f_mem_write),
    .mem_byte_write(f_mem_byte_write), .mem_addr(f_mem_addr),
    .mem_din(f_mem_din), .mem_dout(f_mem_dout), .mem_busy(f_mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_busy   = m_busy_q | hold_busy | stuck;
  assign f_mem_busy = f_busy_q;

  // Controller model for the round-robin instance
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy_q <= 1'b0;
      m_cnt    <= 0;
      mem_dout <= '0;
    end else if (mem_read || mem_write) begin
      m_cnt    <= busy_len;
      m_busy_q <= (busy_len != 0);
      mem_dout <= hash(mem_addr);
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else begin
      m_cnt    <= 0;
      m_busy_q <= 1'b0;
    end
  end

  // Controller model for the fixed-priority instance (busy 2 cycles)
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      f_busy_q   <= 1'b0;
      f_cnt      <= 0;
      f_mem_dout <= '0;
    end else if (f_mem_read || f_mem_write) begin
      f_cnt      <= 2;
      f_busy_q   <= 1'b1;
      f_mem_dout <= hash(f_mem_addr) ^ {15'b0, f_mem_byte_write} ^ f_mem_din;
    end else if (f_cnt > 1) begin
      f_cnt <= f_cnt - 1;
    end else begin
      f_cnt    <= 0;
      f_busy_q <= 1'b0;
    end
  end

  // Activity counters on the round-robin instance
  always @(posedge clk) begin
    if (mem_write) begin
      n_wr         <= n_wr + 1;
      last_wr_addr <= mem_addr;
      last_wr_din  <= mem_din;
      last_wr_bw   <= mem_byte_write;
    end
    if (mem_read)                   n_rd    <= n_rd + 1;
    if (mem_read && mem_byte_write) n_rd_bw <= n_rd_bw + 1;
    if (ack0)                       n_ack0  <= n_ack0 + 1;
    if (ack1)                       n_ack1  <= n_ack1 + 1;
  end

  initial begin
    n_wr = 0; n_rd = 0; n_ack0 = 0; n_ack1 = 0; n_rd_bw = 0;
    last_wr_addr = '0; last_wr_din = '0; last_wr_bw = 1'b0;
  end

  // Waits for an ack on either instance; returns which port and the data.
  task automatic wait_ack(input logic fp, input int limit, output logic got,
                          output logic port, output logic [15:0] rd,
                          output int cyc);
    got = 1'b0; port = 1'b0; rd = '0; cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (fp ? (f_ack0 || f_ack1) : (ack0 || ack1)) begin
        got  = 1'b1;
        port = fp ? f_ack1 : ack1;
        rd   = fp ? f_rdata : rdata;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn    = 1'b0;
    hold_busy = 1'b0;
    stuck     = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int bad_ready;
    int wr0, rd0;
    resetn = 1'b0; hold_busy = 1'b1; stuck = 1'b0; busy_len = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; bw0 = 0; bw1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    f_req0 = 0; f_req1 = 0; f_addr0 = '0; f_addr1 = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready, err, ack0, ack1, mem_read, mem_write} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {ready, err, ack0, ack1, mem_read, mem_write});
    end
    resetn = 1'b1;
    wr0 = n_wr; rd0 = n_rd;
    bad_ready = 0;
    repeat (100) begin
      @(negedge clk);
      if (ready !== 1'b0) bad_ready++;
    end
    n_checks++;
    if (bad_ready != 0) begin
      n_errors++;
      $display("FAIL init_ready_low: ready high in %0d cycles, expected 0", bad_ready);
    end
    n_checks++;
    if ((n_wr - wr0) + (n_rd - rd0) != 0) begin
      n_errors++;
      $display("FAIL init_no_pulses: %0d mem pulses, expected 0",
               (n_wr - wr0) + (n_rd - rd0));
    end
    hold_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++;
      $display("FAIL init_ready_rise: ready=%b expected 1", ready);
    end
  endtask

  task automatic test_single_write();
    logic got, port;
    logic [15:0] rd;
    int cyc, wr0, rd0, a0, a1;
    exp_t e;
    @(negedge clk);
    busy_len = 6;
    wr0 = n_wr; rd0 = n_rd; a0 = n_ack0; a1 = n_ack1;
    addr0 = 22'h000123; wdata0 = 16'hA5A5; we0 = 1'b1; bw0 = 1'b1; req0 = 1'b1;
    sb.push_back('{port: 1'b0, data: hash(22'h000123)});
    wait_ack(1'b0, 60, got, port, rd, cyc);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL write_ack_timeout: no ack in %0d cycles, expected ack", cyc);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (port !== e.port || rd !== e.data) begin
        n_errors++;
        $display("FAIL write_ack: port=%b rdata=%h expected port=%b rdata=%h",
                 port, rd, e.port, e.data);
      end
      n_checks++;
      if (cyc != 9) begin
        n_errors++;
        $display("FAIL write_latency: %0d edges expected 9", cyc);
      end
      n_checks++;
      if (mem_addr !== 22'h000123) begin
        n_errors++;
        $display("FAIL write_addr_hold: mem_addr=%h expected 000123", mem_addr);
      end
    end
    req0 = 1'b0; we0 = 1'b0; bw0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack0 !== 1'b0) begin
      n_errors++;
      $display("FAIL write_ack_width: ack0=%b one cycle after ack, expected 0", ack0);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_wr - wr0 != 1 || n_rd - rd0 != 0) begin
      n_errors++;
      $display("FAIL write_pulses: writes=%0d reads=%0d expected 1 and 0",
               n_wr - wr0, n_rd - rd0);
    end
    n_checks++;
    if (n_ack0 - a0 != 1 || n_ack1 - a1 != 0) begin
      n_errors++;
      $display("FAIL write_ack_count: ack0=%0d ack1=%0d expected 1 and 0",
               n_ack0 - a0, n_ack1 - a1);
    end
    n_checks++;
    if (last_wr_addr !== 22'h000123 || last_wr_din !== 16'hA5A5 || last_wr_bw !== 1'b1) begin
      n_errors++;
      $display("FAIL write_cmd: addr=%h din=%h bw=%b expected 000123 a5a5 1",
               last_wr_addr, last_wr_din, last_wr_bw);
    end
  endtask

  task automatic test_round_robin();
    logic got, port;
    logic [15:0] rd;
    int cyc, rbw0;
    logic [AW-1:0] a [4];
    exp_t e;
    a[0] = 22'h000010; a[1] = 22'h1A0020; a[2] = 22'h000345; a[3] = 22'h2F0F0F;
    do_reset();
    @(negedge clk);
    busy_len = 3;
    rbw0 = n_rd_bw;
    we0 = 0; we1 = 0; bw0 = 1; bw1 = 1;
    addr0 = a[0]; addr1 = a[1]; req0 = 1; req1 = 1;
    sb.push_back('{port: 1'b0, data: hash(a[0])});
    sb.push_back('{port: 1'b1, data: hash(a[1])});
    sb.push_back('{port: 1'b0, data: hash(a[2])});
    sb.push_back('{port: 1'b1, data: hash(a[3])});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b0, 40, got, port, rd, cyc);
      n_checks++;
      if (!got || sb.size() == 0) begin
        n_errors++;
        $display("FAIL rr_ack_%0d: no ack after %0d cycles, expected ack", k, cyc);
      end else begin
        e = sb.pop_front();
        if (port !== e.port || rd !== e.data) begin
          n_errors++;
          $display("FAIL rr_ack_%0d: port=%b rdata=%h expected port=%b rdata=%h",
                   k, port, rd, e.port, e.data);
        end
      end
      if (k == 0) addr0 = a[2];
      if (k == 1) addr1 = a[3];
      if (k == 2) req0 = 0;
      if (k == 3) req1 = 0;
    end
    bw0 = 0; bw1 = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_rd_bw - rbw0 != 0) begin
      n_errors++;
      $display("FAIL rr_read_byte_write: %0d reads with byte_write, expected 0",
               n_rd_bw - rbw0);
    end
    sb.delete();
  endtask

  task automatic test_fixed_prio();
    logic got, port;
    logic [15:0] rd;
    int cyc;
    exp_t e;
    @(negedge clk);
    n_checks++;
    if (f_ready !== 1'b1 || f_err !== 1'b0) begin
      n_errors++;
      $display("FAIL fp_ready: ready=%b err=%b expected 1 0", f_ready, f_err);
    end
    f_addr0 = 22'h000111; f_addr1 = 22'h000222; f_req0 = 1; f_req1 = 1;
    sb.push_back('{port: 1'b0, data: hash(22'h000111)});
    sb.push_back('{port: 1'b0, data: hash(22'h000333)});
    sb.push_back('{port: 1'b0, data: hash(22'h000444)});
    sb.push_back('{port: 1'b1, data: hash(22'h000222)});
    for (int k = 0; k < 4; k++) begin
      wait_ack(1'b1, 40, got, port, rd, cyc);
      n_checks++;
      if (!got || sb.size() == 0) begin
        n_errors++;
        $display("FAIL fp_ack_%0d: no ack after %0d cycles, expected ack", k, cyc);
      end else begin
        e = sb.pop_front();
        if (port !== e.port || rd !== e.data) begin
          n_errors++;
          $display("FAIL fp_ack_%0d: port=%b rdata=%h expected port=%b rdata=%h",
                   k, port, rd, e.port, e.data);
        end
      end
      if (k == 0) f_addr0 = 22'h000333;
      if (k == 1) f_addr0 = 22'h000444;
      if (k == 2) f_req0 = 0;
      if (k == 3) f_req1 = 0;
    end
    sb.delete();
  endtask

  task automatic test_timeout();
    logic got, port;
    logic [15:0] rd;
    int cyc;
    exp_t e;
    do_reset();
    @(negedge clk);
    busy_len = 3; stuck = 1'b1;
    addr0 = 22'h000055; we0 = 0; req0 = 1;
    sb.push_back('{port: 1'b0, data: 16'h0000});
    wait_ack(1'b0, 80, got, port, rd, cyc);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL to_ack_timeout: no ack in %0d cycles, expected ack", cyc);
    end else begin
      e = sb.pop_front();
      if (port !== e.port || rd !== e.data || cyc != 34) begin
        n_errors++;
        $display("FAIL to_ack: port=%b rdata=%h edges=%0d expected port=%b rdata=%h edges=34",
                 port, rd, cyc, e.port, e.data);
      end
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL to_err_set: err=%b expected 1", err);
    end
    req0 = 0; stuck = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL to_err_sticky: err=%b expected 1", err);
    end
    busy_len = 2;
    addr1 = 22'h000077; we1 = 0; req1 = 1;
    sb.push_back('{port: 1'b1, data: hash(22'h000077)});
    wait_ack(1'b0, 40, got, port, rd, cyc);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL to_next_timeout: no ack in %0d cycles, expected ack", cyc);
    end else begin
      e = sb.pop_front();
      if (port !== e.port || rd !== e.data || cyc != 5 || err !== 1'b1) begin
        n_errors++;
        $display("FAIL to_next: port=%b rdata=%h edges=%0d err=%b expected port=%b rdata=%h edges=5 err=1",
                 port, rd, cyc, err, e.port, e.data);
      end
    end
    req1 = 0;
    sb.delete();
  endtask

  task automatic test_reset_mid_access();
    int a0, a1, bad_ready;
    @(negedge clk);
    busy_len = 10;
    a0 = n_ack0; a1 = n_ack1;
    addr1 = 22'h000099; we1 = 0; req1 = 1;
    repeat (4) @(negedge clk);
    #2;
    resetn = 1'b0; hold_busy = 1'b1;
    #1;
    n_checks++;
    if ({ready, err, ack0, ack1, mem_read, mem_write, mem_byte_write} !== 7'b0
        || mem_addr !== '0 || rdata !== '0) begin
      n_errors++;
      $display("FAIL async_reset: flags=%b addr=%h rdata=%h expected all zero",
               {ready, err, ack0, ack1, mem_read, mem_write, mem_byte_write},
               mem_addr, rdata);
    end
    req1 = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready !== 1'b0) bad_ready++;
    end
    n_checks++;
    if (bad_ready != 0 || n_ack0 - a0 != 0 || n_ack1 - a1 != 0) begin
      n_errors++;
      $display("FAIL reset_mid_access: ready_high=%0d acks=%0d expected 0 and 0",
               bad_ready, (n_ack0 - a0) + (n_ack1 - a1));
    end
    hold_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reinit_ready: ready=%b expected 1", ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_fixed_prio();
    test_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
